fetch_unit: RTL

Parametrised instruction-fetch front end for the team's RISC-V datapath. It owns the fetch PC and drives the instruction-memory request/ack handshake (i_address, i_ack, instruction), and it buffers fetched words in a prefetch queue. It presents {pc, instruction} pairs to the decode stage with a valid/ready handshake. Control-flow redirects (branch or jump) flush the queue and restart fetch at a new PC.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 63 ++++++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_state_t : fetch FSM states (IDLE, REQ, DROP)
//   fetch_entry_t : one prefetch-queue entry {pc, instr}. The pc field is
//                   PC_W_MAX wide so a single struct serves any XLEN up to 64;
//                   users zero-extend on write and slice on read.
package fetch_pkg;

  localparam int          INSTR_W   = 32;
  localparam int          PC_STEP   = 4;
  localparam int          PC_W_MAX  = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W_MAX-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: registered synchronous FIFO of fetch_entry_t.
//   clk, rst  : clock, asynchronous active-high reset
//   i_flush   : empty the queue this edge (wins over push/pop)
//   i_push    : write i_wdata at the tail
//   i_pop     : drop the head (ignored when empty)
//   o_valid   : head entry valid
//   o_head    : head entry (holds last value when empty)
//   o_count   : occupancy, 0..QDEPTH
// QDEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int QDEPTH = 4,
  localparam int AW     = $clog2(QDEPTH),
  localparam int CW     = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_wdata,
  input  logic         i_pop,
  output logic         o_valid,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [QDEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // A push into a full queue is only legal when the head leaves the same edge.
  assign w_push = i_push && ((r_count != CW'(QDEPTH)) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the fetch PC, runs the
// instruction-memory req/ack handshake and buffers words in fetch_queue.
//   clk, rst            : clock, asynchronous active-high reset
//   i_req/i_address     : memory request and address (address stable while i_req)
//   i_ack/instruction   : memory ack and returned word
//   redirect/redirect_pc: flush queue and restart fetch at redirect_pc & ~3
//   out_valid/out_ready : head handshake to decode; out_instr/out_pc = head
//   q_count             : queue occupancy
// Optional (FETCH_PERF_EN): perf_fetched counts accepted pushes, perf_stall
// counts cycles with i_req & !i_ack. Neither is cleared by redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int              XLEN     = 32,
  parameter  logic [XLEN-1:0] RESET_PC = '0,
  parameter  int              QDEPTH   = 4,
  localparam int              CW       = $clog2(QDEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               i_req,
  output logic [XLEN-1:0]    i_address,
  input  logic               i_ack,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic [CW-1:0]      q_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_push;
  logic            w_pop;
  logic            w_space;
  logic [CW-1:0]   w_cnt_nxt;
  fetch_entry_t    w_wdata;
  fetch_entry_t    w_head;
  logic            w_unused_lo;

  assign w_redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_lo = ^redirect_pc[1:0];

  assign i_req     = (r_state != IDLE);
  assign i_address = r_addr;

  // Only a live request (REQ) may push; a word acked in DROP, or acked in the
  // same cycle as a redirect, belongs to the abandoned path.
  assign w_push = (r_state == REQ) && i_ack && !redirect;
  assign w_pop  = out_valid && out_ready && !redirect;

  // Occupancy after this edge; a new request is issued only if a slot is
  // free then, which reserves the slot for the single outstanding request.
  assign w_cnt_nxt = redirect ? '0 : (q_count + CW'(w_push) - CW'(w_pop));
  assign w_space   = (w_cnt_nxt < CW'(QDEPTH));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!redirect && w_space) w_state_nxt = REQ;
      REQ: begin
        if (i_ack)         w_state_nxt = w_space ? REQ : IDLE;
        else if (redirect) w_state_nxt = DROP;  // memory cannot abort
      end
      DROP:    if (i_ack) w_state_nxt = w_space ? REQ : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (redirect)    w_pc_nxt = w_redir_pc;
    else if (w_push) w_pc_nxt = r_pc + XLEN'(PC_STEP);
  end

  // r_addr is loaded only when a request starts, so it stays at the old
  // address throughout DROP even though r_pc already points at the target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_state_nxt == REQ) r_addr <= w_pc_nxt;
    end
  end

  always_comb begin
    w_wdata       = '0;
    w_wdata.pc    = PC_W_MAX'(r_pc);
    w_wdata.instr = instruction;
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_valid (out_valid),
    .o_head  (w_head),
    .o_count (q_count)
  );

  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc[XLEN-1:0];

  generate
    if (XLEN < PC_W_MAX) begin : g_pc_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_head.pc[PC_W_MAX-1:XLEN];
    end
  endgenerate

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      r_perf_fetched <= r_perf_fetched + 32'(w_push);
      r_perf_stall   <= r_perf_stall + 32'(i_req && !i_ack);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule
